// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream mux with round-robin arbitration and a registered output stage.
// Optional macro STREAM_MUX_PKT_LOCK_EN adds in_last/out_last and holds the grant for a whole packet.
module stream_mux_rr #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]            in_last,
  output logic                         out_last,
`endif
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);
  logic load, found, xfer, last, rr_found;
  logic [CH_W-1:0] ptr, g, rr_g, cand;
  logic [DATA_WIDTH-1:0] sel_data;
  // Scan downward so the last hit is the nearest valid channel at or above ptr.
  always_comb begin
    rr_found = 1'b0;
    rr_g = '0;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = CH_W'((int'(ptr) + k) % NUM_CH);
      if (in_valid[cand]) begin
        rr_found = 1'b1;
        rr_g = cand;
      end
    end
  end
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic locked;
  logic [CH_W-1:0] lock_ch;
  assign g = locked ? lock_ch : rr_g;
  assign found = locked ? in_valid[lock_ch] : rr_found;
  assign last = in_last[g];
  always_ff @(posedge clk)
    if (rst) begin
      locked <= 1'b0;
      lock_ch <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      locked <= !last;
      lock_ch <= g;
      out_last <= last;
    end
`else
  assign g = rr_g;
  assign found = rr_found;
  assign last = 1'b1;
`endif
  assign load = !out_valid | out_ready;
  assign xfer = load & found & !rst;
  assign in_ready = xfer ? {{(NUM_CH-1){1'b0}}, 1'b1} << g : '0;
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (CH_W'(k) == g) sel_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data <= sel_data;
        out_ch <= g;
        if (last) ptr <= (g == CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
      end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr with a 4-channel and a 3-channel instance.
module tb_stream_mux_rr;
  logic clk, rst;
  logic [31:0] a_in_data;
  logic [3:0] a_in_valid, a_in_ready;
  logic [7:0] a_out_data;
  logic [1:0] a_out_ch;
  logic a_out_valid, a_out_ready;
  logic [23:0] b_in_data;
  logic [2:0] b_in_valid, b_in_ready;
  logic [7:0] b_out_data;
  logic [1:0] b_out_ch;
  logic b_out_valid, b_out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0] a_in_last;
  logic a_out_last, b_out_last;
  logic [2:0] b_in_last;
`endif
  int checks = 0, errors = 0;
  logic [15:0] qa[$], qb[$];

  stream_mux_rr #(.DATA_WIDTH(8), .NUM_CH(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(a_in_last), .out_last(a_out_last),
`endif
    .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid), .out_ready(a_out_ready));

  stream_mux_rr #(.DATA_WIDTH(8), .NUM_CH(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last(b_in_last), .out_last(b_out_last),
`endif
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid), .out_ready(b_out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected entry: [15] out_last, [14] compare out_last, [11:8] channel, [7:0] data.
  always @(negedge clk)
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_beat", {a_out_ch, a_out_data}, 0);
      else begin
        logic [15:0] e;
        e = qa.pop_front();
        chk("a_out_ch", a_out_ch, e[11:8]);
        chk("a_out_data", a_out_data, e[7:0]);
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (e[14]) chk("a_out_last", a_out_last, e[15]);
`endif
      end
    end

  always @(negedge clk)
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_beat", {b_out_ch, b_out_data}, 0);
      else begin
        logic [15:0] e;
        e = qb.pop_front();
        chk("b_out_ch", b_out_ch, e[11:8]);
        chk("b_out_data", b_out_data, e[7:0]);
      end
    end

  initial begin
    rst = 1'b1;
    a_in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    a_in_valid = 4'hF;
    a_out_ready = 1'b1;
    b_in_data = {8'hAA, 8'h55, 8'h33};
    b_in_valid = 3'b000;
    b_out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    a_in_last = 4'hF;
    b_in_last = 3'b111;
`endif
    // Reset with all channels valid
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_b_out_valid", b_out_valid, 0);
    end
    qa.push_back(16'h0010); qa.push_back(16'h0121); qa.push_back(16'h0232);
    qa.push_back(16'h0343); qa.push_back(16'h0010);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("first_grant", a_in_ready, 4'b0001);
    chk("first_out_valid", a_out_valid, 0);
    @(posedge clk);
    @(posedge clk); #1 a_out_ready = 1'b0;
    // Backpressure while holding channel 1's beat
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_out_data", a_out_data, 8'h21);
      chk("bp_out_ch", a_out_ch, 1);
      chk("bp_out_valid", a_out_valid, 1);
    end
    @(posedge clk); #1 a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", a_in_ready, 4'b0100);
    repeat (3) @(posedge clk);
    #1 a_in_valid = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk("drain_out_valid", a_out_valid, 0);
    chk("drain_hold_ch", a_out_ch, 0);
    chk("drain_hold_data", a_out_data, 8'h10);
    chk("rr_queue_empty", qa.size(), 0);
    // Reset mid-stream with a stalled beat and ptr at 2
    @(posedge clk); #1 a_out_ready = 1'b0; a_in_valid = 4'b0010;
    @(posedge clk); #1 a_in_valid = 4'hF; rst = 1'b1;
    @(negedge clk);
    chk("mid_pending_valid", a_out_valid, 1);
    chk("mid_rst_in_ready", a_in_ready, 0);
    @(posedge clk); #1 rst = 1'b0; a_out_ready = 1'b1; qa.push_back(16'h0010);
    @(negedge clk);
    chk("mid_out_valid", a_out_valid, 0);
    chk("mid_grant", a_in_ready, 4'b0001);
    @(posedge clk); #1 a_in_valid = 4'h0;
    // Sparse inputs and wrap on the 3-channel instance
    @(posedge clk); #1 b_in_valid = 3'b100; qb.push_back(16'h02AA);
    @(posedge clk); #1 b_in_valid = 3'b010; qb.push_back(16'h0155);
    @(negedge clk);
    chk("b_grant_ch1", b_in_ready, 3'b010);
    @(posedge clk); #1 b_in_valid = 3'b000;
    @(posedge clk);
    @(negedge clk);
    chk("b_drain_valid", b_out_valid, 0);
    @(posedge clk); #1 b_in_valid = 3'b111;
    qb.push_back(16'h02AA); qb.push_back(16'h0033); qb.push_back(16'h0155);
    @(negedge clk);
    chk("b_ptr2_grant", b_in_ready, 3'b100);
    repeat (3) @(posedge clk);
    #1 b_in_valid = 3'b000;
`ifdef STREAM_MUX_PKT_LOCK_EN
    // Channel 1 packet of three beats while channel 2 waits
    @(posedge clk); #1 a_in_valid = 4'b0110; a_in_last = 4'b0100;
    qa.push_back(16'h4121); qa.push_back(16'h4121); qa.push_back(16'hC121); qa.push_back(16'hC232);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lock_grant", a_in_ready, 4'b0010);
    @(posedge clk); #1 a_in_last = 4'b0110;
    @(posedge clk); #1 a_in_valid = 4'b0100;
    @(posedge clk); #1 a_in_valid = 4'h0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-to-1 streaming multiplexer with round-robin arbitration and a registered output stage. It generalises the 2:1 combinational data mux in two ways: the channel count is configurable, and the select input is replaced by valid/ready handshakes with fair internal arbitration. It sits between several producer streams and one consumer, for example in front of a shared bus or FIFO write port.

## Interface
- `DATA_WIDTH`, default 8: payload width per channel.
- `NUM_CH`, default 4: number of input channels, ≥2, not required to be a power of two.
- `CH_W`, derived localparam `$clog2(NUM_CH)`: width of the channel index.

- `clk`  in  1  clock. Single clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  `NUM_CH*DATA_WIDTH`  packed payloads. Channel i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid`  in  `NUM_CH`  per-channel valid.
- `in_ready`  out  `NUM_CH`  per-channel ready. Combinational, one-hot or zero.
- `out_data`  out  `DATA_WIDTH`  registered payload.
- `out_ch`  out  `CH_W`  registered index of the source channel of `out_data`.
- `out_valid`  out  1  registered valid.
- `out_ready`  in  1  consumer ready.

## Operation
- **Output register.** The block has a single output register holding `out_data`, `out_ch` and `out_valid`.
- **Load enable.** `load = !out_valid | out_ready`. The register can accept a new beat when it is empty or when it is being drained in the same cycle.
- **Arbitration.**
  - Grant goes to the first channel with `in_valid` high, searching from `ptr` upward modulo `NUM_CH`.
  - `in_ready[g] = load & in_valid[g]` for the granted channel `g`. All other `in_ready` bits are 0.
- **Transfer.** An input transfer happens on channel `g` when `in_valid[g] & in_ready[g]`. On that edge:
  - `out_data` is loaded from channel `g`.
  - `out_ch` is loaded with `g`.
  - `out_valid` is set to 1.
  - `ptr` becomes `(g+1) mod NUM_CH`. The wrap from `NUM_CH-1` goes to 0, including for non-power-of-two `NUM_CH`.
- **Drain without refill.** If `load` is high but no channel is valid, `out_valid` becomes 0 and `out_data`/`out_ch` hold their values. `ptr` is unchanged.
- **Stall.** If `out_valid & !out_ready`, all `in_ready` bits are 0 and every register holds.
- **Fairness.** With all channels continuously valid and `out_ready` high, grants cycle 0,1,…,`NUM_CH`-1,0,…. No channel waits more than `NUM_CH-1` transfers.
- **Producer rule.** A producer must hold `in_data` stable while `in_valid` is high and not yet accepted. The block does not check this.

## Timing
- **Reset values:** `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0` (channel 0 has first priority).
- While `rst` is high, `in_ready` is forced to 0.
- **Latency:** one cycle from input transfer to the beat appearing on the output.
- **Throughput:** one beat per cycle while `out_ready` is high.
- **Back-to-back:** a beat drained and a beat loaded in the same cycle produce no bubble.
- **Reset mid-operation:** a pending output beat is discarded and `ptr` returns to 0. Inputs raised during reset are arbitrated from the first cycle after `rst` falls.
- **Combinational path:** `in_ready` depends on `out_ready`, `out_valid`, `in_valid` and `ptr`. There is no path from `in_data` to any output within the same cycle.

## Configuration
- **`STREAM_MUX_PKT_LOCK_EN` defined:**
  - Adds ports `in_last` (in, `NUM_CH`) and `out_last` (out, 1, registered, reset 0).
  - After a transfer with `in_last[g]=0`, the grant is locked to `g`. No other channel is granted until a transfer from `g` with `in_last[g]=1`.
  - `ptr` advances only on that last beat.
  - While locked, if `in_valid[g]=0` then nothing is transferred, even if other channels are valid.
  - Reset clears the lock.
- **Undefined:** no `in_last`/`out_last` ports. Arbitration is per beat, exactly as described in Operation.

## Test plan
- **Reset.** Assert `rst` 2 cycles with all `in_valid` high. Required: `in_ready=0` and `out_valid=0` throughout. After release, the first output has `out_ch=0`.
- **Round robin.** `NUM_CH=4`, channels 0..3 hold `in_data` 0x10, 0x21, 0x32, 0x43, all valid, `out_ready=1`. Required output sequence: `out_ch` 0,1,2,3,0 with data 0x10, 0x21, 0x32, 0x43, 0x10, one beat per cycle, first beat one cycle after release.
- **Backpressure.** With `out_valid=1` and `out_data=0x21`, hold `out_ready=0` for 5 cycles. Required: `in_ready=0`, and `out_data`/`out_ch` stable at 0x21/1. The next transfer after `out_ready` rises is channel 2.
- **Sparse and wrap.** `NUM_CH=3`; only channel 2 valid (0xAA), then only channel 1 valid (0x55). Required: `out_ch` 2 then 1, with `ptr` wrapping to 0 after channel 2. When no input is valid, `out_valid` drops after the drain.
- **Reset mid-stream.** Assert `rst` for 1 cycle while `out_valid=1` and `ptr=2`. Required: `out_valid=0` next cycle, and the next grant goes to channel 0 when all channels are valid.
- **Packet lock (`STREAM_MUX_PKT_LOCK_EN`).** Channel 1 sends 3 beats with `in_last` 0,0,1 while channel 2 is valid throughout. Required: `out_ch` 1,1,1 and then 2, with `out_last=1` only on the third beat.
